hamming_dec: RTL and testbench

Sequential SECDED Hamming decoder, the receive-side counterpart of the ALU's parity/packing ops that build 16-bit codewords from 11-bit messages.
- Accepts a codeword as two bytes over a valid/ready stream, LSW first.
- Computes syndrome and overall parity, corrects any single-bit error and flags double errors.
- Emits the 11-bit message plus a 2-bit status as two bytes, LSW first.
- Keeps saturating error counters for the program-level test harness.

---
 rtl/hamming_dec_if.sv | 21 ++
 rtl/hamming_dec.sv | 147 ++++++++++++++
 tb/tb_hamming_dec.sv | 318 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hamming_dec_if.sv
// Byte-stream bundle between the SECDED decoder and its producer/consumer.
// The decoder is the slave: it takes codeword bytes in and drives result bytes out.
interface hamming_dec_if;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_ready;
    logic [1:0] dec_flags;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, dec_flags
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, dec_flags
    );
endinterface

// File: rtl/hamming_dec.sv
// Sequential SECDED decoder: gathers a 16-bit codeword as two bytes, corrects single
// errors, flags double errors and returns the 11-bit message plus status as two bytes.
module hamming_dec (
    input  logic          clk,
    input  logic          reset_n,
    hamming_dec_if.slave  bus,
    input  logic          clr_cnt,
    output logic [7:0]    corr_cnt,
    output logic [7:0]    dbl_cnt
);

    typedef enum logic [2:0] {
        GET_LSW,
        GET_MSW,
        DECODE,
        SEND_LSW,
        SEND_MSW
    } state_t;

    state_t      r_state;
    logic        r_in_ready;
    logic        r_out_valid;
    logic [7:0]  r_out_data;
    logic [7:0]  r_res_msw;
    logic [1:0]  r_flags;
    logic [7:0]  r_lsw;
    logic [7:0]  r_msw;
    logic [7:0]  r_corr_cnt;
    logic [7:0]  r_dbl_cnt;

    logic [12:0] w_dec;
    logic [1:0]  w_flags;
    logic [10:0] w_msg;
    logic        w_accept;
    logic        w_emit;

    // Returns {flags[1:0], msg[10:0]}; p0 flips are "corrected" by the same rule (c[0]).
    function automatic logic [12:0] decode_word(input logic [15:0] cw);
        logic [3:0]  syn;
        logic        par;
        logic [15:0] c;
        logic [1:0]  flags;
        logic [10:0] msg;
        syn = '0;
        for (int i = 1; i < 16; i++) begin
            for (int k = 0; k < 4; k++) begin
                if (i[k]) syn[k] = syn[k] ^ cw[i];
            end
        end
        par = ^cw;
        c   = cw;
        if (par) c[syn] = ~c[syn];
        if (par)
            flags = 2'b01;
        else if (syn != 4'd0)
            flags = 2'b10;
        else
            flags = 2'b00;
        msg = {c[15:13], c[12:9], c[7:5], c[3]};
        return {flags, msg};
    endfunction

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    always_comb begin
        w_dec    = decode_word({r_msw, r_lsw});
        w_flags  = w_dec[12:11];
        w_msg    = w_dec[10:0];
        w_accept = bus.in_valid & r_in_ready;
        w_emit   = r_out_valid & bus.out_ready;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state     <= GET_LSW;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= 8'h00;
            r_res_msw   <= 8'h00;
            r_flags     <= 2'b00;
        end else begin
            case (r_state)
                GET_LSW: begin
                    // in_ready comes up one cycle after reset release, then stays up
                    r_in_ready <= 1'b1;
                    if (w_accept) begin
                        r_lsw   <= bus.in_data;
                        r_state <= GET_MSW;
                    end
                end
                GET_MSW: begin
                    if (w_accept) begin
                        r_msw      <= bus.in_data;
                        r_in_ready <= 1'b0;
                        r_state    <= DECODE;
                    end
                end
                DECODE: begin
                    r_out_data  <= w_msg[7:0];
                    r_res_msw   <= {w_flags, 3'b000, w_msg[10:8]};
                    r_flags     <= w_flags;
                    r_out_valid <= 1'b1;
                    r_state     <= SEND_LSW;
                end
                SEND_LSW: begin
                    if (w_emit) begin
                        r_out_data <= r_res_msw;
                        r_state    <= SEND_MSW;
                    end
                end
                SEND_MSW: begin
                    if (w_emit) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= GET_LSW;
                    end
                end
                default: begin
                    r_in_ready  <= 1'b0;
                    r_out_valid <= 1'b0;
                    r_state     <= GET_LSW;
                end
            endcase
        end
    end

    // Clear has priority over the DECODE-cycle increment and works in every state.
    always_ff @(posedge clk) begin
        if (!reset_n || clr_cnt) begin
            r_corr_cnt <= 8'h00;
            r_dbl_cnt  <= 8'h00;
        end else if (r_state == DECODE) begin
            if (w_flags == 2'b01) r_corr_cnt <= sat_inc(r_corr_cnt);
            if (w_flags == 2'b10) r_dbl_cnt  <= sat_inc(r_dbl_cnt);
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.dec_flags = r_flags;
    assign corr_cnt      = r_corr_cnt;
    assign dbl_cnt       = r_dbl_cnt;

endmodule

// File: tb/tb_hamming_dec.sv
// Scoreboard bench for hamming_dec: expected result words are queued when a codeword
// is sent and compared when the decoder returns its two result bytes.
module tb_hamming_dec;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       clr_cnt = 1'b0;
    logic [7:0] corr_cnt;
    logic [7:0] dbl_cnt;

    hamming_dec_if bus();

    hamming_dec dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .bus      (bus),
        .clr_cnt  (clr_cnt),
        .corr_cnt (corr_cnt),
        .dbl_cnt  (dbl_cnt)
    );

    always #5 clk = ~clk;

    int          n_vec = 0;
    int          n_err = 0;
    logic [15:0] sb[$];
    logic [7:0]  exp_corr = 8'h00;
    logic [7:0]  exp_dbl  = 8'h00;

    function automatic logic [15:0] enc(input logic [10:0] d);
        logic [15:0] c;
        logic        p;
        c = '0;
        c[3]     = d[0];
        c[7:5]   = d[3:1];
        c[12:9]  = d[7:4];
        c[15:13] = d[10:8];
        for (int k = 0; k < 4; k++) begin
            p = 1'b0;
            for (int i = 1; i < 16; i++)
                if (((i >> k) & 1) == 1) p = p ^ c[i];
            c[1 << k] = p;
        end
        c[0] = ^c[15:1];
        return c;
    endfunction

    function automatic logic [10:0] raw_msg(input logic [15:0] c);
        return {c[15:13], c[12:9], c[7:5], c[3]};
    endfunction

    function automatic logic [15:0] res(input logic [1:0] f, input logic [10:0] m);
        return {f, 3'b000, m};
    endfunction

    function automatic logic [7:0] sat(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    task automatic send_byte(input logic [7:0] b);
        int t = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        while (!bus.in_ready && t < 50) begin
            @(posedge clk); #1; t++;
        end
        if (!bus.in_ready) begin
            n_vec++; n_err++;
            $display("FAIL send_timeout: in_ready=%b required 1", bus.in_ready);
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic send_word(input logic [15:0] cw, input logic [15:0] exp, input int gap);
        sb.push_back(exp);
        if (exp[15:14] == 2'b01) exp_corr = sat(exp_corr);
        if (exp[15:14] == 2'b10) exp_dbl  = sat(exp_dbl);
        send_byte(cw[7:0]);
        repeat (gap) begin @(posedge clk); #1; end
        send_byte(cw[15:8]);
    endtask

    task automatic recv_byte(output logic [7:0] d, output logic [1:0] f);
        int t = 0;
        bus.out_ready = 1'b1;
        while (!bus.out_valid && t < 50) begin
            @(posedge clk); #1; t++;
        end
        if (!bus.out_valid) begin
            n_vec++; n_err++;
            $display("FAIL recv_timeout: out_valid=%b required 1", bus.out_valid);
        end
        d = bus.out_data;
        f = bus.dec_flags;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic recv_word(output logic [15:0] obs, output logic [15:0] exp, output logic [3:0] fl);
        logic [7:0] lo, hi;
        logic [1:0] f0, f1;
        recv_byte(lo, f0);
        recv_byte(hi, f1);
        obs = {hi, lo};
        fl  = {f1, f0};
        exp = (sb.size() > 0) ? sb.pop_front() : 16'hxxxx;
    endtask

    task automatic test_reset();
        bus.in_valid = 1'b0; bus.in_data = 8'h00; bus.out_ready = 1'b0;
        reset_n = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        n_vec++;
        if ({bus.in_ready, bus.out_valid, bus.out_data, bus.dec_flags} !== 12'h000) begin
            n_err++;
            $display("FAIL reset_outputs: rdy=%b vld=%b data=%h flags=%b required 0/0/00/00",
                     bus.in_ready, bus.out_valid, bus.out_data, bus.dec_flags);
        end
        n_vec++;
        if (corr_cnt !== 8'h00 || dbl_cnt !== 8'h00) begin
            n_err++;
            $display("FAIL reset_counters: corr=%0d dbl=%0d required 0/0", corr_cnt, dbl_cnt);
        end
        reset_n = 1'b1;
        n_vec++;
        if (bus.in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL reset_ready_early: in_ready=%b required 0", bus.in_ready);
        end
        @(posedge clk); #1;
        n_vec++;
        if (bus.in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_ready_rise: in_ready=%b required 1", bus.in_ready);
        end
    endtask

    task automatic test_clean_latency();
        logic [15:0] o, e;
        logic [3:0]  f;
        send_word(16'h0000, res(2'b00, 11'h000), 0);
        n_vec++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL latency_decode: vld=%b rdy=%b required 0/0", bus.out_valid, bus.in_ready);
        end
        @(posedge clk); #1;
        n_vec++;
        if (bus.out_valid !== 1'b1) begin
            n_err++;
            $display("FAIL latency_valid: out_valid=%b required 1", bus.out_valid);
        end
        recv_word(o, e, f);
        n_vec++;
        if (o !== e || f !== {e[15:14], e[15:14]}) begin
            n_err++;
            $display("FAIL clean_zero: got %h flags %b required %h", o, f, e);
        end
        n_vec++;
        if (corr_cnt !== 8'd0 || dbl_cnt !== 8'd0) begin
            n_err++;
            $display("FAIL clean_counters: corr=%0d dbl=%0d required 0/0", corr_cnt, dbl_cnt);
        end
    endtask

    task automatic test_directed();
        logic [15:0] cws [5] = '{16'h0008, 16'h0001, 16'hFFFF, 16'hDFFF, 16'h0003};
        logic [15:0] exps[5] = '{16'h4000, 16'h4000, 16'h07FF, 16'h47FF, 16'h8000};
        logic [7:0]  ec  [5] = '{8'd1, 8'd2, 8'd2, 8'd3, 8'd3};
        logic [7:0]  ed  [5] = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd1};
        logic [15:0] o, e;
        logic [3:0]  f;
        for (int i = 0; i < 5; i++) begin
            send_word(cws[i], exps[i], 0);
            recv_word(o, e, f);
            n_vec++;
            if (o !== e || f !== {e[15:14], e[15:14]}) begin
                n_err++;
                $display("FAIL directed_%0d: cw %h got %h flags %b required %h", i, cws[i], o, f, e);
            end
            n_vec++;
            if (corr_cnt !== ec[i] || dbl_cnt !== ed[i]) begin
                n_err++;
                $display("FAIL directed_cnt_%0d: corr=%0d dbl=%0d required %0d/%0d",
                         i, corr_cnt, dbl_cnt, ec[i], ed[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [15:0] o, e;
        logic [3:0]  f;
        logic [7:0]  d0;
        logic [1:0]  f0;
        send_word(enc(11'h5A3), res(2'b00, 11'h5A3), 3);
        @(posedge clk); #1;
        d0 = bus.out_data;
        f0 = bus.dec_flags;
        bus.in_valid = 1'b1;
        bus.in_data  = 8'hAA;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            n_vec++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== d0 || bus.dec_flags !== f0 || bus.in_ready !== 1'b0) begin
                n_err++;
                $display("FAIL backpressure_%0d: vld=%b data=%h flags=%b rdy=%b required 1/%h/%b/0",
                         i, bus.out_valid, bus.out_data, bus.dec_flags, bus.in_ready, d0, f0);
            end
        end
        bus.in_valid = 1'b0;
        recv_word(o, e, f);
        n_vec++;
        if (o !== e || f !== {e[15:14], e[15:14]}) begin
            n_err++;
            $display("FAIL backpressure_word: got %h flags %b required %h", o, f, e);
        end
    endtask

    task automatic test_saturation();
        logic [15:0] o, e, cw;
        logic [3:0]  f;
        logic [10:0] m;
        for (int n = 0; n < 260; n++) begin
            m  = 11'($urandom_range(0, 2047));
            cw = enc(m) ^ (16'd1 << $urandom_range(0, 15));
            send_word(cw, res(2'b01, m), n % 3);
            recv_word(o, e, f);
            n_vec++;
            if (o !== e || f !== {e[15:14], e[15:14]}) begin
                n_err++;
                $display("FAIL single_rand_%0d: cw %h got %h flags %b required %h", n, cw, o, f, e);
            end
        end
        n_vec++;
        if (corr_cnt !== exp_corr || corr_cnt !== 8'd255) begin
            n_err++;
            $display("FAIL corr_saturate: corr=%0d required 255 (model %0d)", corr_cnt, exp_corr);
        end
        // clear lands in the DECODE cycle of another single-error word
        send_word(enc(11'h2C4) ^ 16'h0200, res(2'b01, 11'h2C4), 0);
        clr_cnt = 1'b1;
        @(posedge clk); #1;
        clr_cnt = 1'b0;
        exp_corr = 8'd0; exp_dbl = 8'd0;
        n_vec++;
        if (corr_cnt !== 8'd0 || dbl_cnt !== 8'd0) begin
            n_err++;
            $display("FAIL clr_vs_inc: corr=%0d dbl=%0d required 0/0", corr_cnt, dbl_cnt);
        end
        recv_word(o, e, f);
        n_vec++;
        if (o !== e || f !== {e[15:14], e[15:14]}) begin
            n_err++;
            $display("FAIL clr_word: got %h flags %b required %h", o, f, e);
        end
        cw = enc(11'h6B1) ^ 16'h0060;
        send_word(cw, res(2'b10, raw_msg(cw)), 1);
        recv_word(o, e, f);
        n_vec++;
        if (o !== e || f !== {e[15:14], e[15:14]}) begin
            n_err++;
            $display("FAIL double_rand: cw %h got %h flags %b required %h", cw, o, f, e);
        end
        n_vec++;
        if (corr_cnt !== exp_corr || dbl_cnt !== exp_dbl) begin
            n_err++;
            $display("FAIL after_clr_cnt: corr=%0d dbl=%0d required %0d/%0d",
                     corr_cnt, dbl_cnt, exp_corr, exp_dbl);
        end
    endtask

    task automatic test_reset_midword();
        logic [15:0] o, e;
        logic [3:0]  f;
        send_byte(8'hFF);
        reset_n = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;
        exp_corr = 8'd0; exp_dbl = 8'd0;
        n_vec++;
        if (corr_cnt !== 8'd0 || dbl_cnt !== 8'd0 || bus.in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL midword_reset: corr=%0d dbl=%0d rdy=%b required 0/0/1", corr_cnt, dbl_cnt, bus.in_ready);
        end
        send_word(enc(11'h123), res(2'b00, 11'h123), 0);
        recv_word(o, e, f);
        n_vec++;
        if (o !== e || f !== {e[15:14], e[15:14]}) begin
            n_err++;
            $display("FAIL midword_word: got %h flags %b required %h", o, f, e);
        end
        n_vec++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_left: %0d entries required 0", sb.size());
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_clean_latency();
        test_directed();
        test_backpressure();
        test_saturation();
        test_reset_midword();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
